// File: rtl/branch_resolve_unit_pkg.sv
// bpu_pkg: types and constants shared by the branch predictor and the
// branch resolve unit.
package bpu_pkg;

   // Redirect FSM: IDLE waits for a mispredict, PEND holds the redirect
   typedef enum logic {
      IDLE = 1'b0,
      PEND = 1'b1
   } bru_state_e;

   // Not-taken fall-through skips the branch and its delay slot
   localparam int unsigned BR_FALLTHRU_OFS = 8;

   localparam int unsigned BPU_PC_W = 32;

   // Training packet returned to the direction predictor
   typedef struct packed {
      logic                valid;
      logic [BPU_PC_W-1:0] pc;
      logic                taken;
   } bpu_upd_t;

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Redirect/flush handshake towards fetch plus the predictor training strobe.
// master: branch_resolve_unit, slave: fetch / predictor side.
interface branch_resolve_unit_if #(
   parameter int PC_W = 32
);
   logic            redirect_valid;
   logic [PC_W-1:0] redirect_pc;
   logic            redirect_ready;
   logic            flush_req;
   logic            upd_valid;
   logic [PC_W-1:0] upd_pc;
   logic            upd_taken;

   modport master (
      output redirect_valid, redirect_pc, flush_req,
      output upd_valid, upd_pc, upd_taken,
      input  redirect_ready
   );

   modport slave (
      input  redirect_valid, redirect_pc, flush_req,
      input  upd_valid, upd_pc, upd_taken,
      output redirect_ready
   );
endinterface

// File: rtl/branch_resolve_unit_sat_counter.sv
// sat_counter: W-bit event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   output logic [W-1:0] count
);

   // Count one event per cycle, holding once saturated
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + W'(1);
      end
   end

endmodule

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: resolves E-stage branches against the Decode
// prediction, raises the fetch redirect / flush on a mispredict and emits a
// one-cycle training packet per resolved branch.
// Optional feature macro: BRU_PERF_CNT_EN (saturating perf counters).
module branch_resolve_unit
   import bpu_pkg::*;
#(
   parameter int PC_W  = 32,
   parameter int CNT_W = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   stallE,
   input  logic                   flushE,
   input  logic                   branchD,
   input  logic                   pred_takeD,
   input  logic [PC_W-1:0]        pcD,
   input  logic [PC_W-1:0]        targetD,
   input  logic                   actual_takeE,
   branch_resolve_unit_if.master  rdIf,
   output logic [CNT_W-1:0]       perf_branches,
   output logic [CNT_W-1:0]       perf_mispred
);

   logic            validE;
   logic            predTakeE;
   logic [PC_W-1:0] pcE;
   logic [PC_W-1:0] targetE;

   bru_state_e      state;
   bru_state_e      nextState;
   logic            mispredE;
   logic            takeMispred;
   logic            updNext;
   logic [PC_W-1:0] correctPc;

   logic [PC_W-1:0] redirectPcQ;
   logic            updValidQ;
   logic [PC_W-1:0] updPcQ;
   logic            updTakenQ;

   // D->E capture; flush clears the valid bit even while stalled
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         validE    <= 1'b0;
         predTakeE <= 1'b0;
         pcE       <= '0;
         targetE   <= '0;
      end else if (flushE) begin
         validE    <= 1'b0;
      end else if (!stallE) begin
         validE    <= branchD;
         predTakeE <= pred_takeD;
         pcE       <= pcD;
         targetE   <= targetD;
      end
   end

   assign mispredE  = validE & (predTakeE != actual_takeE);
   assign correctPc = actual_takeE ? targetE : (pcE + PC_W'(BR_FALLTHRU_OFS));

   // Redirect FSM state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Next state; E branches seen while PEND are squashed younger work, so
   // they neither start a redirect nor train the predictor
   always_comb begin
      nextState   = state;
      takeMispred = 1'b0;
      updNext     = 1'b0;
      case (state)
         IDLE: begin
            updNext = validE;
            if (mispredE) begin
               nextState   = PEND;
               takeMispred = 1'b1;
            end
         end
         PEND: begin
            if (rdIf.redirect_ready) begin
               nextState = IDLE;
            end
         end
         default: nextState = IDLE;
      endcase
   end

   // Latch the correct PC on entry to PEND and the training packet in M
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         redirectPcQ <= '0;
         updValidQ   <= 1'b0;
         updPcQ      <= '0;
         updTakenQ   <= 1'b0;
      end else begin
         if (takeMispred) begin
            redirectPcQ <= correctPc;
         end
         updValidQ <= updNext;
         if (updNext) begin
            updPcQ    <= pcE;
            updTakenQ <= actual_takeE;
         end
      end
   end

   assign rdIf.redirect_valid = (state == PEND);
   assign rdIf.flush_req      = (state == PEND);
   assign rdIf.redirect_pc    = redirectPcQ;
   assign rdIf.upd_valid      = updValidQ;
   assign rdIf.upd_pc         = updPcQ;
   assign rdIf.upd_taken      = updTakenQ;

`ifdef BRU_PERF_CNT_EN
   sat_counter #(.W(CNT_W)) uBranchCnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (updValidQ),
      .count (perf_branches)
   );

   sat_counter #(.W(CNT_W)) uMispredCnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (takeMispred),
      .count (perf_mispred)
   );
`else
   assign perf_branches = '0;
   assign perf_mispred  = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit. Expected training packets and
// redirect PCs are queued as stimulus is driven and checked by a monitor.
// Build with BRU_PERF_CNT_EN to exercise the 2-bit saturating counters.
module tb_branch_resolve_unit;
   import bpu_pkg::*;

`ifdef BRU_PERF_CNT_EN
   localparam int CNT_W    = 2;
   localparam int PERF_EXP = 3;
`else
   localparam int CNT_W    = 32;
   localparam int PERF_EXP = 0;
`endif

   logic clk = 1'b0;
   logic rst;
   logic stallE, flushE, branchD, pred_takeD, actual_takeE;
   logic [31:0] pcD, targetD;
   logic [CNT_W-1:0] perf_branches, perf_mispred;

   int checks = 0;
   int errors = 0;

   bpu_upd_t    updQ[$];
   logic [31:0] rdQ[$];
   logic        prevRv = 1'b0;
   logic [31:0] heldPc = '0;

   branch_resolve_unit_if #(.PC_W(32)) rdIf ();

   branch_resolve_unit #(.PC_W(32), .CNT_W(CNT_W)) dut (
      .clk           (clk),
      .rst           (rst),
      .stallE        (stallE),
      .flushE        (flushE),
      .branchD       (branchD),
      .pred_takeD    (pred_takeD),
      .pcD           (pcD),
      .targetD       (targetD),
      .actual_takeE  (actual_takeE),
      .rdIf          (rdIf),
      .perf_branches (perf_branches),
      .perf_mispred  (perf_mispred)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout required=finish");
      $fatal(1);
   end

   // Scoreboard monitor: training packets and redirect PC at redirect start,
   // then redirect PC stability while the redirect is held
   always @(negedge clk) begin : monitor
      bpu_upd_t    e;
      logic [31:0] p;
      if (!rst) begin
         prevRv <= 1'b0;
      end else begin
         if (rdIf.upd_valid) begin
            checks++;
            if (updQ.size() == 0) begin
               errors++;
               $display("FAIL upd_unexpected got pc=%h taken=%b required=no update", rdIf.upd_pc, rdIf.upd_taken);
            end else begin
               e = updQ.pop_front();
               if ({rdIf.upd_pc, rdIf.upd_taken} !== {e.pc, e.taken}) begin
                  errors++;
                  $display("FAIL upd_pkt got pc=%h taken=%b required pc=%h taken=%b", rdIf.upd_pc, rdIf.upd_taken, e.pc, e.taken);
               end
            end
         end
         if (rdIf.redirect_valid) begin
            checks++;
            if (!prevRv) begin
               if (rdQ.size() == 0) begin
                  errors++;
                  heldPc <= '0;
                  $display("FAIL redirect_unexpected got pc=%h required=no redirect", rdIf.redirect_pc);
               end else begin
                  p = rdQ.pop_front();
                  heldPc <= p;
                  if (rdIf.redirect_pc !== p) begin
                     errors++;
                     $display("FAIL redirect_pc got=%h required=%h", rdIf.redirect_pc, p);
                  end
               end
            end else if (rdIf.redirect_pc !== heldPc) begin
               errors++;
               $display("FAIL redirect_pc_stable got=%h required=%h", rdIf.redirect_pc, heldPc);
            end
         end
         prevRv <= rdIf.redirect_valid;
      end
   end

   // Inputs change at a negedge and are consumed by the next posedge;
   // returns at the following negedge where outputs are sampled
   task automatic drive(input logic bD, input logic pT, input logic [31:0] pc,
                        input logic [31:0] tgt, input logic aT, input logic rdy);
      branchD             = bD;
      pred_takeD          = pT;
      pcD                 = pc;
      targetD             = tgt;
      actual_takeE        = aT;
      rdIf.redirect_ready = rdy;
      @(negedge clk);
   endtask

   task automatic test_reset;
      rst = 1'b0; stallE = 1'b0; flushE = 1'b0;
      drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
      drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
      checks++; if (rdIf.redirect_valid !== 1'b0) begin errors++; $display("FAIL rst_rv got=%b required=0", rdIf.redirect_valid); end
      checks++; if (rdIf.flush_req !== 1'b0) begin errors++; $display("FAIL rst_flush got=%b required=0", rdIf.flush_req); end
      checks++; if (rdIf.redirect_pc !== 32'h0) begin errors++; $display("FAIL rst_rdpc got=%h required=0", rdIf.redirect_pc); end
      checks++; if (rdIf.upd_valid !== 1'b0) begin errors++; $display("FAIL rst_updv got=%b required=0", rdIf.upd_valid); end
      checks++; if (rdIf.upd_pc !== 32'h0) begin errors++; $display("FAIL rst_updpc got=%h required=0", rdIf.upd_pc); end
      checks++; if (rdIf.upd_taken !== 1'b0) begin errors++; $display("FAIL rst_updt got=%b required=0", rdIf.upd_taken); end
      checks++; if (perf_branches !== '0) begin errors++; $display("FAIL rst_perfb got=%0d required=0", perf_branches); end
      checks++; if (perf_mispred !== '0) begin errors++; $display("FAIL rst_perfm got=%0d required=0", perf_mispred); end
      rst = 1'b1;
   endtask

   task automatic test_mispred_taken;
      updQ.push_back('{valid: 1'b1, pc: 32'h0040_0000, taken: 1'b1});
      rdQ.push_back(32'h0040_0100);
      drive(1'b1, 1'b0, 32'h0040_0000, 32'h0040_0100, 1'b0, 1'b1);
      drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b1);
      checks++; if (rdIf.redirect_valid !== 1'b1) begin errors++; $display("FAIL mt_rv_t2 got=%b required=1", rdIf.redirect_valid); end
      checks++; if (rdIf.flush_req !== 1'b1) begin errors++; $display("FAIL mt_flush_t2 got=%b required=1", rdIf.flush_req); end
      checks++; if (rdIf.upd_valid !== 1'b1) begin errors++; $display("FAIL mt_updv_t2 got=%b required=1", rdIf.upd_valid); end
      drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
      checks++; if (rdIf.redirect_valid !== 1'b0) begin errors++; $display("FAIL mt_rv_t3 got=%b required=0", rdIf.redirect_valid); end
      checks++; if (rdIf.upd_valid !== 1'b0) begin errors++; $display("FAIL mt_updv_t3 got=%b required=0", rdIf.upd_valid); end
   endtask

   task automatic test_wrap;
      updQ.push_back('{valid: 1'b1, pc: 32'hFFFF_FFFC, taken: 1'b0});
      rdQ.push_back(32'h0000_0004);
      drive(1'b1, 1'b1, 32'hFFFF_FFFC, 32'h0000_1000, 1'b0, 1'b1);
      drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
      checks++; if (rdIf.redirect_valid !== 1'b1) begin errors++; $display("FAIL wrap_rv got=%b required=1", rdIf.redirect_valid); end
      drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
      checks++; if (rdIf.redirect_valid !== 1'b0) begin errors++; $display("FAIL wrap_rv_end got=%b required=0", rdIf.redirect_valid); end
   endtask

   task automatic test_pend_hold;
      updQ.push_back('{valid: 1'b1, pc: 32'h0040_0200, taken: 1'b1});
      rdQ.push_back(32'h0040_0800);
      drive(1'b1, 1'b0, 32'h0040_0200, 32'h0040_0800, 1'b0, 1'b0);
      // younger branch enters D as the first one resolves
      drive(1'b1, 1'b0, 32'h0040_0204, 32'h0040_0900, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) begin
         checks++; if (rdIf.redirect_valid !== 1'b1) begin errors++; $display("FAIL pend_rv_c%0d got=%b required=1", i, rdIf.redirect_valid); end
         checks++; if (rdIf.redirect_pc !== 32'h0040_0800) begin errors++; $display("FAIL pend_pc_c%0d got=%h required=00400800", i, rdIf.redirect_pc); end
         if (i == 3) break;
         if (i == 2) drive(1'b1, 1'b0, 32'h0040_0300, 32'h0040_0a00, 1'b1, 1'b0);
         else        drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
         checks++; if (rdIf.upd_valid !== 1'b0) begin errors++; $display("FAIL pend_noupd_c%0d got=%b required=0", i, rdIf.upd_valid); end
      end
      // ready and a fresh mispredict in the same cycle: the detection is dropped
      drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b1);
      checks++; if (rdIf.redirect_valid !== 1'b0) begin errors++; $display("FAIL pend_release got=%b required=0", rdIf.redirect_valid); end
      checks++; if (rdIf.upd_valid !== 1'b0) begin errors++; $display("FAIL drop_noupd got=%b required=0", rdIf.upd_valid); end
      drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
      checks++; if (rdIf.redirect_valid !== 1'b0) begin errors++; $display("FAIL drop_norv got=%b required=0", rdIf.redirect_valid); end
   endtask

   task automatic test_correct_pred;
      updQ.push_back('{valid: 1'b1, pc: 32'h0040_0020, taken: 1'b1});
      drive(1'b1, 1'b1, 32'h0040_0020, 32'h0040_0400, 1'b0, 1'b1);
      drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b1);
      checks++; if (rdIf.redirect_valid !== 1'b0) begin errors++; $display("FAIL cp_rv got=%b required=0", rdIf.redirect_valid); end
      checks++; if (rdIf.upd_valid !== 1'b1) begin errors++; $display("FAIL cp_updv got=%b required=1", rdIf.upd_valid); end
      drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
      checks++; if (rdIf.upd_valid !== 1'b0) begin errors++; $display("FAIL cp_updv_end got=%b required=0", rdIf.upd_valid); end
   endtask

   task automatic test_flush_stall;
      stallE = 1'b1; flushE = 1'b1;
      drive(1'b1, 1'b0, 32'h0040_0040, 32'h0040_0500, 1'b0, 1'b1);
      stallE = 1'b0; flushE = 1'b0;
      drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b1);
      checks++; if (rdIf.upd_valid !== 1'b0) begin errors++; $display("FAIL fs_updv got=%b required=0", rdIf.upd_valid); end
      checks++; if (rdIf.redirect_valid !== 1'b0) begin errors++; $display("FAIL fs_rv got=%b required=0", rdIf.redirect_valid); end
   endtask

   task automatic test_back_to_back;
      updQ.push_back('{valid: 1'b1, pc: 32'h0040_1000, taken: 1'b1});
      updQ.push_back('{valid: 1'b1, pc: 32'h0040_1004, taken: 1'b0});
      updQ.push_back('{valid: 1'b1, pc: 32'h0040_1008, taken: 1'b1});
      drive(1'b1, 1'b1, 32'h0040_1000, 32'h0040_2000, 1'b0, 1'b1);
      drive(1'b1, 1'b0, 32'h0040_1004, 32'h0040_3000, 1'b1, 1'b1);
      checks++; if (rdIf.upd_valid !== 1'b1) begin errors++; $display("FAIL b2b_upd0 got=%b required=1", rdIf.upd_valid); end
      drive(1'b1, 1'b1, 32'h0040_1008, 32'h0040_4000, 1'b0, 1'b1);
      checks++; if (rdIf.upd_valid !== 1'b1) begin errors++; $display("FAIL b2b_upd1 got=%b required=1", rdIf.upd_valid); end
      drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b1);
      checks++; if (rdIf.upd_valid !== 1'b1) begin errors++; $display("FAIL b2b_upd2 got=%b required=1", rdIf.upd_valid); end
      drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
      checks++; if (rdIf.upd_valid !== 1'b0) begin errors++; $display("FAIL b2b_end got=%b required=0", rdIf.upd_valid); end
   endtask

   task automatic test_reset_in_pend;
      updQ.push_back('{valid: 1'b1, pc: 32'h0040_0600, taken: 1'b1});
      rdQ.push_back(32'h0040_0700);
      drive(1'b1, 1'b0, 32'h0040_0600, 32'h0040_0700, 1'b0, 1'b0);
      drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
      checks++; if (rdIf.redirect_valid !== 1'b1) begin errors++; $display("FAIL rp_rv_pre got=%b required=1", rdIf.redirect_valid); end
      #2 rst = 1'b0;
      #1;
      checks++; if (rdIf.redirect_valid !== 1'b0) begin errors++; $display("FAIL rp_rv_async got=%b required=0", rdIf.redirect_valid); end
      checks++; if (rdIf.flush_req !== 1'b0) begin errors++; $display("FAIL rp_flush_async got=%b required=0", rdIf.flush_req); end
      @(negedge clk);
      rst = 1'b1;
      drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
      checks++; if (rdIf.redirect_valid !== 1'b0) begin errors++; $display("FAIL rp_rv_after got=%b required=0", rdIf.redirect_valid); end
   endtask

   task automatic test_perf;
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 5; i++) begin
         logic [31:0] pc;
         pc = 32'h0040_5000 + 32'(i * 16);
         updQ.push_back('{valid: 1'b1, pc: pc, taken: 1'b1});
         rdQ.push_back(pc + 32'h100);
         drive(1'b1, 1'b0, pc, pc + 32'h100, 1'b0, 1'b1);
         drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b1);
         drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
      end
      checks++; if (perf_mispred !== CNT_W'(PERF_EXP)) begin errors++; $display("FAIL perf_mispred got=%0d required=%0d", perf_mispred, PERF_EXP); end
      checks++; if (perf_branches !== CNT_W'(PERF_EXP)) begin errors++; $display("FAIL perf_branches got=%0d required=%0d", perf_branches, PERF_EXP); end
   endtask

   initial begin
      test_reset();
      test_mispred_taken();
      test_wrap();
      test_pend_hold();
      test_correct_pred();
      test_flush_stall();
      test_back_to_back();
      test_reset_in_pend();
      test_perf();
      drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
      drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
      checks++; if (updQ.size() != 0) begin errors++; $display("FAIL upd_leftover got=%0d required=0", updQ.size()); end
      checks++; if (rdQ.size() != 0) begin errors++; $display("FAIL redirect_leftover got=%0d required=0", rdQ.size()); end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
